// File: rtl/branch_pkg.sv
// branch_pkg: shared branch funct3 codes and BHT counter encoding.
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_state_e;
  localparam bht_state_e BHT_RESET_STATE = WNT;
endpackage

// File: rtl/bht.sv
// bht: 2-bit saturating counter table, combinational read, read-before-write update.
module bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] if_idx,
  output logic             rd_taken,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic             upd_en,
  input  logic             upd_taken
);
  bht_state_e cnt [ENTRIES];
  bht_state_e nxt;
  assign rd_taken = cnt[if_idx][1];
  always_comb
    nxt = upd_taken ? (cnt[ex_idx] == ST  ? ST  : bht_state_e'(cnt[ex_idx] + 2'd1))
                    : (cnt[ex_idx] == SNT ? SNT : bht_state_e'(cnt[ex_idx] - 2'd1));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= BHT_RESET_STATE;
    else if (upd_en)
      cnt[ex_idx] <= nxt;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch decision, mispredict redirect and BHT owner.
// Define BRANCH_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_is_jump_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  output logic        br_unsigned_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic legal, decision, actual_taken, upd_en;
  logic unused_pc;
  assign unused_pc = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};
  // funct3[2] picks less vs equal, funct3[0] inverts; 010/011 are illegal
  always_comb begin
    legal         = ex_funct3_i[2] | ~ex_funct3_i[1];
    decision      = legal & ((ex_funct3_i[2] ? br_less_i : br_equal_i) ^ ex_funct3_i[0]);
    actual_taken  = ex_valid_i & (ex_is_jump_i | (ex_is_branch_i & decision));
    upd_en        = ex_valid_i & ex_is_branch_i & ~ex_is_jump_i & legal;
    redirect_o    = rst_ni & ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & (actual_taken != ex_pred_taken_i);
    redirect_pc_o = actual_taken ? ex_target_i : ex_pc_i + 32'd4;
    br_unsigned_o = ex_funct3_i[2] & ex_funct3_i[1];
  end
  bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .if_idx    (if_pc_i[IDX_W+1:2]),
    .rd_taken  (pred_taken_o),
    .ex_idx    (ex_pc_i[IDX_W+1:2]),
    .upd_en    (upd_en),
    .upd_taken (decision)
  );
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (upd_en && stat_branches_o != 32'hFFFF_FFFF) stat_branches_o <= stat_branches_o + 32'd1;
      if (redirect_o && stat_mispred_o != 32'hFFFF_FFFF) stat_mispred_o <= stat_mispred_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vectors for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
  import branch_pkg::*;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i, ex_target_i;
  logic        ex_pred_taken_i, br_less_i, br_equal_i;
  logic        br_unsigned_o, redirect_o;
  logic [31:0] redirect_pc_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_o, stat_mispred_o;
`endif
  int n_cmp = 0;
  int n_err = 0;

  branch_resolve dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .if_pc_i         (if_pc_i),
    .pred_taken_o    (pred_taken_o),
    .ex_valid_i      (ex_valid_i),
    .ex_is_branch_i  (ex_is_branch_i),
    .ex_is_jump_i    (ex_is_jump_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_pc_i         (ex_pc_i),
    .ex_target_i     (ex_target_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .br_less_i       (br_less_i),
    .br_equal_i      (br_equal_i),
    .br_unsigned_o   (br_unsigned_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches_o (stat_branches_o),
    .stat_mispred_o  (stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic br(input logic v, input logic b, input logic j, input logic [2:0] f3,
                    input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pred, input logic lt, input logic eq);
    ex_valid_i = v; ex_is_branch_i = b; ex_is_jump_i = j; ex_funct3_i = f3;
    ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pred; br_less_i = lt; br_equal_i = eq;
    #1;
  endtask

  task automatic idle();
    br(1'b0, 1'b0, 1'b0, F3_BEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    if_pc_i = 32'h100;
    br(1'b1, 1'b0, 1'b1, F3_BEQ, 32'h100, 32'h400, 1'b0, 1'b0, 1'b0);
    chk("rst_pred", pred_taken_o, 1'b0);
    chk("rst_redirect_forced", redirect_o, 1'b0);
    nxt();
    rst_ni = 1'b1;
    idle();
    chk("post_rst_pred", pred_taken_o, 1'b0);
    nxt();
    // BEQ taken, predicted not taken, at 0x100 (WNT -> WT)
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    chk("beq_t_redirect", redirect_o, 1'b1);
    chk("beq_t_pc", redirect_pc_o, 32'h200);
    chk("beq_t_same_cycle_pred", pred_taken_o, 1'b0);
    nxt(); idle();
    chk("after_1t_pred", pred_taken_o, 1'b1);
    nxt();
    // three more taken: WT -> ST -> ST -> ST (high saturation)
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    chk("beq_t_correct_noredir", redirect_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1); nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1); nxt();
    // not taken: ST -> WT
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("beq_nt_redirect", redirect_o, 1'b1);
    chk("beq_nt_pc", redirect_pc_o, 32'h104);
    nxt(); idle();
    chk("st_to_wt_pred", pred_taken_o, 1'b1);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0); nxt(); idle();
    chk("wt_to_wnt_pred", pred_taken_o, 1'b0);
    nxt();
    // two not taken: WNT -> SNT -> SNT, then two taken: WNT, WT
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
    chk("beq_nt_correct_noredir", redirect_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0); nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1); nxt(); idle();
    chk("snt_to_wnt_pred", pred_taken_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1); nxt(); idle();
    chk("wnt_to_wt_pred", pred_taken_o, 1'b1);
    nxt();
    // PC wrap at top of address space, read-before-write
    if_pc_i = 32'hFFFF_FFFC;
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b1);
    chk("wrap_train_pc", redirect_pc_o, 32'h10);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("wrap_redirect", redirect_o, 1'b1);
    chk("wrap_pc", redirect_pc_o, 32'h0);
    chk("wrap_old_pred", pred_taken_o, 1'b1);
    nxt(); idle();
    chk("wrap_new_pred", pred_taken_o, 1'b0);
    nxt();
    // jumps and branch+jump never update the BHT
    if_pc_i = 32'h180;
    br(1'b1, 1'b0, 1'b1, F3_BEQ, 32'h180, 32'h400, 1'b0, 1'b0, 1'b0);
    chk("jal_redirect", redirect_o, 1'b1);
    chk("jal_pc", redirect_pc_o, 32'h400);
    nxt();
    br(1'b1, 1'b1, 1'b1, F3_BEQ, 32'h180, 32'h404, 1'b0, 1'b0, 1'b1);
    chk("br_jmp_redirect", redirect_o, 1'b1);
    chk("br_jmp_pc", redirect_pc_o, 32'h404);
    nxt();
    br(1'b1, 1'b1, 1'b0, 3'b010, 32'h180, 32'h500, 1'b0, 1'b1, 1'b1);
    chk("f3_010_noredir", redirect_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, 3'b011, 32'h180, 32'h500, 1'b1, 1'b1, 1'b1);
    chk("f3_011_redirect", redirect_o, 1'b1);
    chk("f3_011_pc", redirect_pc_o, 32'h184);
    nxt();
    br(1'b0, 1'b1, 1'b0, F3_BEQ, 32'h180, 32'h600, 1'b0, 1'b0, 1'b1);
    chk("invalid_noredir", redirect_o, 1'b0);
    nxt(); idle();
    chk("jump_illegal_no_update", pred_taken_o, 1'b0);
    nxt();
    // comparator select and remaining funct3 decodes
    br(1'b1, 1'b1, 1'b0, F3_BLTU, 32'h340, 32'h700, 1'b0, 1'b1, 1'b0);
    chk("bltu_unsigned", br_unsigned_o, 1'b1);
    chk("bltu_pc", redirect_pc_o, 32'h700);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BGEU, 32'h340, 32'h700, 1'b1, 1'b0, 1'b0);
    chk("bgeu_unsigned", br_unsigned_o, 1'b1);
    chk("bgeu_noredir", redirect_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BLT, 32'h340, 32'h700, 1'b1, 1'b1, 1'b0);
    chk("blt_signed", br_unsigned_o, 1'b0);
    chk("blt_noredir", redirect_o, 1'b0);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BGE, 32'h340, 32'h700, 1'b1, 1'b1, 1'b0);
    chk("bge_redirect", redirect_o, 1'b1);
    chk("bge_pc", redirect_pc_o, 32'h344);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BNE, 32'h340, 32'h700, 1'b0, 1'b0, 1'b0);
    chk("bne_t_pc", redirect_pc_o, 32'h700);
    nxt();
    br(1'b1, 1'b1, 1'b0, F3_BNE, 32'h340, 32'h700, 1'b1, 1'b0, 1'b1);
    chk("bne_nt_redirect", redirect_o, 1'b1);
    chk("bne_nt_pc", redirect_pc_o, 32'h344);
    nxt();
    // asynchronous reset mid-cycle after training 0x100 to WT
    if_pc_i = 32'h100;
    idle();
    chk("pre_midrst_pred", pred_taken_o, 1'b1);
    br(1'b1, 1'b0, 1'b1, F3_BEQ, 32'h100, 32'h400, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_pred", pred_taken_o, 1'b0);
    chk("midrst_redirect", redirect_o, 1'b0);
    nxt();
    rst_ni = 1'b1;
    idle();
    chk("post_midrst_pred", pred_taken_o, 1'b0);
    if_pc_i = 32'hFFFF_FFFC;
    #1;
    chk("post_midrst_pred_top", pred_taken_o, 1'b0);
    nxt();
    // statistics activity: two legal branches, two redirects
    if_pc_i = 32'h100;
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1); nxt();
    br(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1); nxt();
    br(1'b1, 1'b0, 1'b1, F3_BEQ, 32'h100, 32'h400, 1'b0, 1'b0, 1'b0); nxt();
    idle();
    chk("final_pred", pred_taken_o, 1'b1);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches_o, 32'd2);
    chk("stat_mispred", stat_mispred_o, 32'd2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Downstream consumer of the branch comparator in the EX stage.
- Turns `br_less`/`br_equal` plus the branch funct3 into an actual taken/not-taken decision.
- Compares that decision with the direction predicted at IF and issues a same-cycle PC redirect on mispredict.
- Owns the 2-bit-saturating-counter branch history table (BHT) that produces the IF-stage direction prediction; also drives the comparator's unsigned-select.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, range 4..1024.
- IDX_W, $clog2(BHT_ENTRIES), index width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- if_pc_i  input  32  fetch PC used for the prediction lookup.
- pred_taken_o  output  1  IF prediction; 1 = predicted taken.
- ex_valid_i  input  1  EX holds a valid, non-stalled instruction this cycle.
- ex_is_branch_i  input  1  EX instruction is a conditional branch.
- ex_is_jump_i  input  1  EX instruction is JAL/JALR.
- ex_funct3_i  input  3  branch funct3.
- ex_pc_i  input  32  PC of the EX instruction.
- ex_target_i  input  32  branch/jump target computed by the ALU.
- ex_pred_taken_i  input  1  prediction carried from IF down the pipe.
- br_less_i  input  1  from comparator.
- br_equal_i  input  1  from comparator.
- br_unsigned_o  output  1  to comparator unsigned select.
- redirect_o  output  1  mispredict; flush IF/ID and load redirect_pc_o.
- redirect_pc_o  output  32  corrected fetch PC.

Behaviour:
- Index: `if_idx = if_pc_i[IDX_W+1:2]`; `ex_idx = ex_pc_i[IDX_W+1:2]`.
- `pred_taken_o` = MSB of `bht[if_idx]`. Combinational read, zero latency.
- `br_unsigned_o` = `ex_funct3_i[2] & ex_funct3_i[1]`. Purely combinational.
- Decision by funct3:
  - 000 BEQ → `eq`
  - 001 BNE → `!eq`
  - 100 BLT → `lt`
  - 101 BGE → `!lt`
  - 110 BLTU → `lt`
  - 111 BGEU → `!lt`
  - 010/011 → not taken, no BHT update.
- actual_taken = (`ex_valid_i` & `ex_is_branch_i` & decision) | (`ex_valid_i` & `ex_is_jump_i`).
- `redirect_o` = `ex_valid_i` & (`ex_is_branch_i` | `ex_is_jump_i`) & (actual_taken != `ex_pred_taken_i`). Combinational, same cycle as EX.
- `redirect_pc_o` = actual_taken ? `ex_target_i` : `ex_pc_i` + 4.
  - 32-bit add, wraps modulo 2^32.
  - Value is don't-care when `redirect_o` = 0, but driven deterministically.
- Counter encoding:
  - 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST).
- BHT update at the clock edge when `ex_valid_i` & `ex_is_branch_i` & legal funct3:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - Jumps never update.
- Same-cycle read/write to the same index: IF sees the pre-update value (read-before-write); the new value is visible next cycle.
- `ex_is_branch_i` and `ex_is_jump_i` both high: treated as a jump, no BHT update.
- Reset (asynchronous, any time, including mid-update): all counters = 01 (WNT).
  - `pred_taken_o` = 0 during and after reset until an update occurs.
  - `redirect_o` is forced 0 while `rst_ni` = 0.
- No internal stall port: upstream deasserts `ex_valid_i` when EX is stalled or flushed, so an instruction is never counted twice.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs `stat_branches_o[31:0]` and `stat_mispred_o[31:0]`.
  - `stat_branches_o` increments on each valid legal branch; `stat_mispred_o` increments on each cycle with `redirect_o` = 1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `branch_pkg` holds:
  - funct3 localparams F3_BEQ..F3_BGEU.
  - Enum `bht_state_e` {SNT, WNT, WT, ST}.
  - Constant BHT_RESET_STATE = WNT.
- One sub-module, `bht`:
  - Counter array with async reset.
  - One combinational read port (`if_idx`) and one write port (`ex_idx`, `upd_en`, `upd_taken`) with saturating update.
- Decision and redirect logic stays in `branch_resolve`.

Test Plan:
- Reset, then `if_pc_i` = 0x100 → `pred_taken_o` = 0.
  - Assert `rst_ni` low mid-run after training → all entries return to WNT.
- BEQ at `ex_pc_i` = 0x100, `br_equal_i` = 1, `ex_pred_taken_i` = 0, `ex_target_i` = 0x200 → `redirect_o` = 1, `redirect_pc_o` = 0x200.
  - Next cycle `if_pc_i` = 0x100 → `pred_taken_o` = 1.
- Training to saturation at 0x100:
  - Three taken BEQs → counter = ST.
  - One not-taken → WT, prediction still 1.
  - Second not-taken → WNT, prediction 0.
- BLTU / BGEU: funct3 110 → `br_unsigned_o` = 1; 100 → 0.
  - BGEU with `br_less_i` = 0, `ex_pred_taken_i` = 1 → `redirect_o` = 0.
- Not-taken mispredict at `ex_pc_i` = 0xFFFF_FFFC, `ex_pred_taken_i` = 1, `br_equal_i` = 0 (BEQ) → `redirect_pc_o` = 0x0000_0000 (wrap).
  - Same cycle, `if_pc_i` = 0xFFFF_FFFC sees the old counter value.
- JAL with `ex_pred_taken_i` = 0, `ex_target_i` = 0x400 → `redirect_o` = 1, `redirect_pc_o` = 0x400, BHT unchanged.
  - funct3 010 with `ex_is_branch_i` = 1 → no redirect if pred 0, no update.
